// File: rtl/i2c_pkg.sv
// Shared types and helpers for the AXIS-to-I2C write master.
package i2c_pkg;

   typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   // clk cycles per SCL quarter, never below one
   function automatic int calc_div(input int clk_freq, input int i2c_freq);
      int d;
      d = clk_freq / (4 * i2c_freq);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period strobe generator: tick every DIV clocks plus a 2-bit quarter index.
module i2c_clk_div #(
   parameter int DIV = 1
) (
   input  logic       clk,
   input  logic       arstn,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = !clr && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         cnt     <= '0;
         quarter <= '0;
      end else if (clr) begin
         cnt     <= '0;
         quarter <= '0;
      end else if (tick) begin
         cnt     <= '0;
         quarter <= quarter + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/axis_i2c_writer.sv
// AXI-Stream to I2C write master: one START/addr+W/data bytes/STOP transaction per word.
module axis_i2c_writer
   import i2c_pkg::*;
#(
   parameter int         AXIS_DATA_WIDTH = 16,
   parameter int         CLK_FREQ        = 50_000_000,
   parameter int         I2C_FREQ        = 100_000,
   parameter logic [6:0] SLAVE_ADDR      = 7'h3C
) (
   input  logic                       clk,
   input  logic                       arstn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   output logic                       scl,
   output logic                       sda_o,
   input  logic                       sda_i,
   output logic                       busy,
   output logic                       nack_err
);

   localparam int NBYTES = AXIS_DATA_WIDTH / 8;
   localparam int DIV    = calc_div(CLK_FREQ, I2C_FREQ);
   localparam int BCW    = $clog2(NBYTES + 1);

   state_t                     state, state_n;
   logic [AXIS_DATA_WIDTH-1:0] word;
   logic [7:0]                 sreg;
   logic [2:0]                 bit_cnt;
   logic [BCW-1:0]             byte_cnt;
   logic                       ack_bit;
   logic                       tick, clr, phase_end, hs, load_next, nack_set;
   logic [1:0]                 quarter;

   i2c_clk_div #(.DIV(DIV)) u_div (
      .clk     (clk),
      .arstn   (arstn),
      .clr     (clr),
      .tick    (tick),
      .quarter (quarter)
   );

   assign s_axis_tready = (state == IDLE) && arstn;
   assign hs            = s_axis_tvalid && s_axis_tready;
   assign busy          = (state != IDLE);
   assign phase_end     = tick && (quarter == Q3);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      scl       = 1'b1;
      sda_o     = 1'b1;
      clr       = 1'b0;
      load_next = 1'b0;
      nack_set  = 1'b0;
      case (state)
         IDLE: begin
            clr = 1'b1;
            if (hs) state_n = START;
         end
         START: begin
            scl   = (quarter != Q3);
            sda_o = (quarter == Q0);
            if (phase_end) state_n = BYTE;
         end
         BYTE: begin
            scl   = quarter[1];
            sda_o = sreg[7];
            if (phase_end && bit_cnt == 3'd7) state_n = ACK;
         end
         ACK: begin
            scl = quarter[1];
            if (phase_end) begin
               // a NACK drops whatever data bytes are still queued
               if (ack_bit) begin
                  nack_set = 1'b1;
                  state_n  = STOP;
               end else if (byte_cnt != BCW'(NBYTES)) begin
                  load_next = 1'b1;
                  state_n   = BYTE;
               end else begin
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            scl   = (quarter != Q0);
            sda_o = quarter[1];
            if (phase_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         word     <= '0;
         sreg     <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         ack_bit  <= 1'b0;
         nack_err <= 1'b0;
      end else begin
         nack_err <= nack_set;
         if (hs) begin
            word     <= s_axis_tdata;
            sreg     <= {SLAVE_ADDR, 1'b0};
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end
         if (state == BYTE && phase_end) begin
            sreg    <= {sreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (state == ACK && tick && quarter == Q2) ack_bit <= sda_i;
         if (load_next) begin
            sreg     <= word[AXIS_DATA_WIDTH-1 -: 8];
            word     <= word << 8;
            byte_cnt <= byte_cnt + BCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_axis_i2c_writer.sv
// Directed bench for axis_i2c_writer with a bus monitor decoding SCL/SDA and timing.
module tb_axis_i2c_writer;

   logic        clk = 1'b0;
   logic        arstn;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [15:0] s_axis_tdata;
   logic        scl, sda_o, sda_i, busy, nack_err;

   int errors = 0;
   int checks = 0;

   axis_i2c_writer #(
      .AXIS_DATA_WIDTH (16),
      .CLK_FREQ        (4_000_000),
      .I2C_FREQ        (100_000),
      .SLAVE_ADDR      (7'h3C)
   ) dut (
      .clk           (clk),
      .arstn         (arstn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .scl           (scl),
      .sda_o         (sda_o),
      .sda_i         (sda_i),
      .busy          (busy),
      .nack_err      (nack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // monitor state (written only by the monitor process)
   int         cyc, starts, stops, nack_cnt, ack_slot, bitcnt, run, lo_len, busy_run;
   bit         in_tx, first_lo, fell, pend, p_scl, p_sda, p_busy;
   logic [7:0] cur;
   logic [7:0] bytes[$];
   int         busy_lens[$];
   int         hs_t[$];
   int         nack_slot;
   logic [7:0] exp_q[$];

   initial begin : mon
      sda_i = 1'b0;
      cyc = 0; starts = 0; stops = 0; nack_cnt = 0; ack_slot = 0;
      bitcnt = 0; run = 0; lo_len = 0; busy_run = 0;
      in_tx = 0; first_lo = 0; fell = 0; pend = 0; p_scl = 1; p_sda = 1; p_busy = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!arstn) begin
            in_tx = 0; pend = 0; bitcnt = 0; busy_run = 0; p_busy = 0; run = 0;
            p_scl = scl; p_sda = sda_o; sda_i = 1'b0;
         end else begin
            if (s_axis_tvalid && s_axis_tready) hs_t.push_back(cyc);
            if (nack_err) nack_cnt++;
            if (busy) busy_run++;
            else if (p_busy) begin
               busy_lens.push_back(busy_run);
               busy_run = 0;
            end
            p_busy = busy;
            // SDA may only move under a high SCL as START or STOP
            if (p_scl && scl && p_sda && !sda_o) begin
               chk("start_outside_tx", 32'(in_tx), 32'd0);
               in_tx = 1; first_lo = 1; fell = 0; bitcnt = 0; ack_slot = 0; starts++;
            end else if (p_scl && scl && !p_sda && sda_o) begin
               chk("stop_in_tx", 32'(in_tx), 32'd1);
               chk("stop_align", 32'(bitcnt), 32'd1);
               chk("scl_lo_stop", 32'(lo_len), 32'd10);
               pend = 0; in_tx = 0; bitcnt = 0; stops++;
            end
            if (in_tx && !p_scl && scl) begin
               if (first_lo) begin
                  chk("scl_lo_first", 32'(run), 32'd30);
                  first_lo = 0;
               end else begin
                  lo_len = run;
                  pend   = 1;
               end
               if (bitcnt == 8) begin
                  chk("ack_released", 32'(sda_o), 32'd1);
                  ack_slot++;
                  sda_i = (ack_slot == nack_slot);
                  bytes.push_back(cur);
                  bitcnt = 0;
               end else begin
                  cur = {cur[6:0], sda_o};
                  bitcnt++;
               end
            end
            if (in_tx && p_scl && !scl) begin
               if (fell) chk("scl_hi", 32'(run), 32'd20);
               if (pend) chk("scl_lo", 32'(lo_len), 32'd20);
               pend = 0; fell = 1; sda_i = 1'b0;
            end
            if (scl != p_scl) run = 1;
            else              run++;
            p_scl = scl;
            p_sda = sda_o;
         end
      end
   end

   task automatic send(input logic [15:0] d, input bit keep);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("hs_wait_bound", 32'(n < 4000), 32'd1);
      @(posedge clk);
      #2;
      if (!keep) begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = 16'hDEAD;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait_bound", 32'(n < 5000), 32'd1);
      @(posedge clk);
      #2;
   endtask

   task automatic chk_bytes(input string tag, input int base);
      chk($sformatf("%s_count", tag), 32'(bytes.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < bytes.size())
            chk($sformatf("%s_byte%0d", tag, i), 32'(bytes[base+i]), 32'(exp_q[i]));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int b, bl, st, sp, nk, h;
      arstn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; nack_slot = 0;
      repeat (3) @(negedge clk);
      chk("rst_scl", 32'(scl), 32'd1);
      chk("rst_sda", 32'(sda_o), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_nack", 32'(nack_err), 32'd0);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk); #2 arstn = 1'b1;
      @(negedge clk);
      chk("idle_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk); #2;

      // single word
      b = bytes.size(); bl = busy_lens.size(); st = starts; sp = stops; nk = nack_cnt;
      send(16'hA55A, 0);
      wait_idle();
      exp_q = '{8'h78, 8'hA5, 8'h5A};
      chk_bytes("single", b);
      chk("single_starts", 32'(starts - st), 32'd1);
      chk("single_stops", 32'(stops - sp), 32'd1);
      chk("single_busy_len", 32'(busy_lens[bl]), 32'd1160);
      chk("single_nack", 32'(nack_cnt - nk), 32'd0);

      // back-pressure with tvalid held across three words
      b = bytes.size(); bl = busy_lens.size(); h = hs_t.size(); nk = nack_cnt;
      send(16'h0102, 1);
      send(16'h0304, 1);
      send(16'h0506, 0);
      wait_idle();
      chk("bp_handshakes", 32'(hs_t.size() - h), 32'd3);
      for (int i = 1; i < 3; i++)
         if (h + i < hs_t.size())
            chk($sformatf("bp_gap%0d", i), 32'(hs_t[h+i] - hs_t[h+i-1] >= 1160), 32'd1);
      exp_q = '{8'h78, 8'h01, 8'h02, 8'h78, 8'h03, 8'h04, 8'h78, 8'h05, 8'h06};
      chk_bytes("bp", b);
      chk("bp_busy_count", 32'(busy_lens.size() - bl), 32'd3);
      for (int i = 0; i < 3; i++)
         if (bl + i < busy_lens.size())
            chk($sformatf("bp_busy_len%0d", i), 32'(busy_lens[bl+i]), 32'd1160);
      chk("bp_nack", 32'(nack_cnt - nk), 32'd0);

      // address NACK
      b = bytes.size(); bl = busy_lens.size(); sp = stops; nk = nack_cnt;
      nack_slot = 1;
      send(16'hBEEF, 0);
      wait_idle();
      nack_slot = 0;
      exp_q = '{8'h78};
      chk_bytes("anack", b);
      chk("anack_pulse", 32'(nack_cnt - nk), 32'd1);
      chk("anack_stops", 32'(stops - sp), 32'd1);
      chk("anack_busy_len", 32'(busy_lens[bl]), 32'd440);

      // data NACK on the first data byte
      b = bytes.size(); bl = busy_lens.size(); nk = nack_cnt;
      nack_slot = 2;
      send(16'h9C3F, 0);
      wait_idle();
      nack_slot = 0;
      exp_q = '{8'h78, 8'h9C};
      chk_bytes("dnack", b);
      chk("dnack_pulse", 32'(nack_cnt - nk), 32'd1);
      chk("dnack_busy_len", 32'(busy_lens[bl]), 32'd800);

      // reset during bit 4 of the first data byte
      b = bytes.size();
      send(16'h1234, 0);
      repeat (575) @(negedge clk);
      @(posedge clk); #2 arstn = 1'b0;
      #1;
      chk("mrst_scl", 32'(scl), 32'd1);
      chk("mrst_sda", 32'(sda_o), 32'd1);
      chk("mrst_tready", 32'(s_axis_tready), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_partial", 32'(bytes.size() - b), 32'd1);
      @(posedge clk); #2 arstn = 1'b1;
      @(negedge clk);
      chk("mrst_tready_after", 32'(s_axis_tready), 32'd1);
      @(posedge clk); #2;
      b = bytes.size(); bl = busy_lens.size(); nk = nack_cnt;
      send(16'hC3E1, 0);
      wait_idle();
      exp_q = '{8'h78, 8'hC3, 8'hE1};
      chk_bytes("post_rst", b);
      chk("post_rst_busy_len", 32'(busy_lens[bl]), 32'd1160);
      chk("post_rst_nack", 32'(nack_cnt - nk), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
